// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera frame capture block: mode and FSM encodings,
// plus the buffer size helper.
package cam_pkg;

  typedef enum logic [1:0] {
    ModeSingle     = 2'd0,
    ModeCont       = 2'd1,
    ModeLumaSingle = 2'd2,
    ModeLumaCont   = 2'd3
  } cam_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StCapt = 2'd2,
    StHold = 2'd3
  } cam_state_e;

  function automatic int unsigned bytes_per_frame(input int unsigned w, input int unsigned h,
                                                  input int unsigned bpp);
    return w * h * bpp;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers the sensor inputs once and derives frame/line boundary pulses from the
// registered copies.
module cam_sync_edge (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] pdata_i,
  output logic       href_o,
  output logic [7:0] pdata_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       line_end_o
);

  logic       vsync_q, vsync_d1_q;
  logic       href_q, href_d1_q;
  logic [7:0] pdata_q;

  // Reset vsync low so a frame already running after reset never yields a start pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vsync_q    <= 1'b0;
      vsync_d1_q <= 1'b0;
      href_q     <= 1'b0;
      href_d1_q  <= 1'b0;
      pdata_q    <= 8'd0;
    end else begin
      vsync_q    <= vsync_i;
      vsync_d1_q <= vsync_q;
      href_q     <= href_i;
      href_d1_q  <= href_o;
      pdata_q    <= pdata_i;
    end
  end

  // href during vertical blanking is ignored.
  assign href_o        = href_q & ~vsync_q;
  assign pdata_o       = pdata_q;
  assign frame_start_o = vsync_d1_q & ~vsync_q;
  assign frame_end_o   = ~vsync_d1_q & vsync_q;
  assign line_end_o    = href_d1_q & ~href_o;

endmodule

// File: rtl/cam_frame_capture.sv
// Captures a windowed region of a parallel camera frame into a byte-wide buffer,
// with single-shot / continuous and luma-only modes plus per-frame status.
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 200,
  parameter int unsigned BPP    = 2,
  parameter int unsigned X_OFF  = 0,
  parameter int unsigned Y_OFF  = 0,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [7:0]        pdata_i,
  input  logic [1:0]        mode_i,
  input  logic              cap_req_i,
  output logic              cap_ack_o,
  output logic              cap_busy_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic [ADDR_W:0]   frame_bytes_o,
  output logic              frame_err_o,
  output logic [7:0]        frame_cnt_o
);

  localparam logic [ADDR_W:0]   Total    = (ADDR_W+1)'(bytes_per_frame(IMG_W, IMG_H, BPP));
  localparam logic [ADDR_W-1:0] AddrMax  = ADDR_W'(bytes_per_frame(IMG_W, IMG_H, BPP) - 1);
  localparam logic [15:0]       XLo      = 16'(X_OFF * BPP);
  localparam logic [15:0]       YLo      = 16'(Y_OFF);
  localparam logic [15:0]       WinBytes = 16'(IMG_W * BPP);
  localparam logic [15:0]       WinLines = 16'(IMG_H);

  logic       href, frame_start, frame_end, line_end;
  logic [7:0] pdata;

  cam_sync_edge u_sync (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .vsync_i       (vsync_i),
    .href_i        (href_i),
    .pdata_i       (pdata_i),
    .href_o        (href),
    .pdata_o       (pdata),
    .frame_start_o (frame_start),
    .frame_end_o   (frame_end),
    .line_end_o    (line_end)
  );

  cam_mode_e mode;
  logic      luma, cont;
  assign mode = cam_mode_e'(mode_i);
  assign luma = (mode == ModeLumaSingle) || (mode == ModeLumaCont);
  assign cont = (mode == ModeCont) || (mode == ModeLumaCont);

  cam_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_ack_o  = 1'b0;
    cap_busy_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (cap_req_i) state_d = StArm;
      end
      StArm: begin
        cap_busy_o = 1'b1;
        if (!cap_req_i) begin
          state_d = StIdle;
        end else if (frame_start) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        cap_busy_o = 1'b1;
        if (frame_end) state_d = (cont && cap_req_i) ? StCapt : StHold;
      end
      StHold: begin
        cap_ack_o = 1'b1;
        if (!cap_req_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [15:0]       byte_q, line_q;
  logic [ADDR_W:0]   issued_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [ADDR_W:0]   frame_bytes_q;
  logic              frame_err_q;
  logic [7:0]        frame_cnt_q;

  // Offsets computed one bit wider so a position before the window shows up as negative.
  logic [16:0] line_rel, byte_rel;
  logic        line_in, byte_in, in_win, wr_go, capt_end, restart;

  assign line_rel = {1'b0, line_q} - {1'b0, YLo};
  assign byte_rel = {1'b0, byte_q} - {1'b0, XLo};
  assign line_in  = !line_rel[16] && (line_rel[15:0] < WinLines);
  assign byte_in  = !byte_rel[16] && (byte_rel[15:0] < WinBytes);
  assign in_win   = href && (state_q == StCapt) && line_in && byte_in && (!luma || !byte_q[0]);
  assign wr_go    = in_win && (issued_q < Total);
  assign capt_end = (state_q == StCapt) && frame_end;
  assign restart  = capt_end && cont && cap_req_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_q        <= 16'd0;
      line_q        <= 16'd0;
      issued_q      <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 8'd0;
      frame_bytes_q <= '0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      if (!href) begin
        byte_q <= 16'd0;
      end else if (byte_q != 16'hFFFF) begin
        byte_q <= byte_q + 16'd1;
      end

      if (frame_start || restart) begin
        line_q <= 16'd0;
      end else if (line_end && (line_q != 16'hFFFF)) begin
        line_q <= line_q + 16'd1;
      end

      wr_en_q <= wr_go;
      if (wr_go) wr_data_q <= pdata;

      // Issue count bounds the writes; the address trails it by one cycle with wr_en.
      if (frame_start || restart) begin
        issued_q  <= '0;
        wr_addr_q <= '0;
      end else begin
        if (wr_go) issued_q <= issued_q + (ADDR_W+1)'(1);
        if (wr_en_q && (wr_addr_q != AddrMax)) wr_addr_q <= wr_addr_q + ADDR_W'(1);
      end

      // Status samples the pre-clear counters on the same edge that restarts them.
      if (capt_end) begin
        frame_bytes_q <= issued_q;
        frame_err_q   <= !(!line_rel[16] && (line_rel[15:0] >= WinLines));
        frame_cnt_q   <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign frame_bytes_o = frame_bytes_q;
  assign frame_err_o   = frame_err_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: doc/cam_frame_capture.md
CAM_FRAME_CAPTURE -- requirements
Module: cam_frame_capture

Interface
REQ-001 Parameter IMG_W, default 320, meaning active pixels kept per line.
REQ-002 Parameter IMG_H, default 200, meaning active lines kept per frame.
REQ-003 Parameter BPP, default 2, meaning bytes per sensor pixel (1 or 2).
REQ-004 Parameter X_OFF, default 0, meaning pixels skipped at line start before the window.
REQ-005 Parameter Y_OFF, default 0, meaning lines skipped at frame start before the window.
REQ-006 Parameter ADDR_W, default 17, meaning write-address width.
REQ-007 Ports: clk in 1 pixel clock; reset in 1 sync active-high reset; one clock, reset is synchronous and active-high.
REQ-008 Ports: vsync in 1 (high = blanking); href in 1 line valid; pdata in 8 sensor byte.
REQ-009 Ports: mode in 2 (0 single-shot, 1 continuous, 2 luma-only single-shot, 3 luma-only continuous).
REQ-010 Ports: cap_req in 1 level request; cap_ack out 1 frame held; cap_busy out 1 armed or capturing.
REQ-011 Ports: wr_en out 1; wr_addr out ADDR_W; wr_data out 8 buffer write port.
REQ-012 Ports: frame_bytes out ADDR_W+1 bytes written last frame; frame_err out 1 last frame short; frame_cnt out 8 completed frames.

Function
REQ-013 vsync, href and pdata SHALL each be registered once; all decisions use the registered copies.
REQ-014 Frame start = falling edge of registered vsync; frame end = rising edge.
REQ-015 FSM states SHALL be IDLE, ARM, CAPT, HOLD.
REQ-016 IDLE -> ARM when cap_req=1; ARM -> CAPT on frame start; CAPT -> HOLD on frame end (single-shot modes) or CAPT -> CAPT with counters cleared (continuous modes while cap_req=1).
REQ-017 HOLD -> IDLE when cap_req=0; cap_req dropping in ARM -> IDLE; in CAPT it ends capture at next frame end, then HOLD.
REQ-018 cap_ack SHALL be 1 only in HOLD; cap_busy SHALL be 1 in ARM or CAPT.
REQ-019 Byte counter per line SHALL clear when registered href=0 and increment per byte with href=1; line counter SHALL increment on each href falling edge, clear on frame start.
REQ-020 A byte SHALL be written only in CAPT when Y_OFF <= line < Y_OFF+IMG_H and X_OFF*BPP <= byte < (X_OFF+IMG_W)*BPP.
REQ-021 Luma-only modes SHALL additionally require even byte index (YUYV order), halving bytes per line.
REQ-022 wr_en/wr_data SHALL be registered: asserted one clk after the registered byte, i.e. two clk after pdata at the pin.
REQ-023 wr_addr SHALL start at 0 each frame and increment by 1 after every write; it SHALL saturate at IMG_W*IMG_H*BPP-1 (no wrap), further writes suppressed.
REQ-024 Extra href bytes or lines beyond the window SHALL be dropped without error.
REQ-025 On frame end, frame_bytes SHALL load the write count; frame_err SHALL set if window lines seen < IMG_H, else clear.
REQ-026 frame_cnt SHALL increment (mod 256) on every frame end reached in CAPT.
REQ-027 Frame start and frame end in the same cycle cannot occur; href while registered vsync=1 SHALL be ignored.
REQ-028 In continuous modes the frame-end cycle SHALL update status before counters clear for the next frame.

Reset
REQ-029 reset=1 at any clk edge, including mid-capture, SHALL force IDLE, wr_en=0, wr_addr=0, wr_data=0, cap_ack=0, cap_busy=0, frame_bytes=0, frame_err=0, frame_cnt=0, all counters 0.
REQ-030 First capture after reset SHALL require a fresh frame start; a frame already in progress is never partially written.

Structure
REQ-031 Shared package cam_pkg SHALL hold the mode encodings, FSM state encoding and a bytes-per-frame constant function.
REQ-032 One sub-module cam_sync_edge SHALL register vsync/href/pdata and emit frame_start, frame_end, line_end pulses.

Verification
REQ-033 IMG_W=4, IMG_H=2, BPP=2, mode 0, 3 lines of 10 bytes: 16 writes addr 0..15, data = first 8 bytes of lines 1-2, cap_ack=1, frame_bytes=16, frame_err=0.
REQ-034 Same, X_OFF=1, Y_OFF=1, 4 lines: writes bytes 2..9 of lines 2-3, frame_bytes=16.
REQ-035 Mode 2, bytes 0x10..0x19 per line: only even-index bytes written (0x10,0x12,0x14,0x16), frame_bytes=8.
REQ-036 Mode 1, cap_req held across 3 frames: frame_cnt=3, wr_addr returns to 0 each frame start, cap_ack never 1.
REQ-037 Frame with 1 line only: frame_err=1, frame_bytes=8; reset asserted mid-line: wr_en=0 next clk, IDLE, next frame not written until cap_req.
